tile_layer_gen: RTL and testbench

//  Parametrised scrolling 8x8 tile layer, successor to the fixed 4-plane background layer.

---
 rtl/tile_layer_gen.sv | 200 ++++++++++++++++++++
 tb/tb_tile_layer_gen.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_layer_gen.sv
// Scrolling 8x8 tile layer: CPU-writable dual-byte tilemap, one-tile-ahead ROM prefetch over
// a req/ack handshake, PLANES-wide pixel shifters with flip, and CPU wait-state generation.
module tile_layer_gen #(
  parameter int unsigned PLANES      = 4,
  parameter int unsigned MAP_AW      = 11,
  parameter int unsigned CODE_W      = 12,
  parameter int unsigned COLOR_W     = 4,
  parameter int unsigned ROM_AW      = 17,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                        master_clk,
  input  logic                        reset,
  input  logic                        ce_pix,
  input  logic [7:0]                  VPIXSCRL,
  input  logic [8:0]                  HPIXSCRL,
  input  logic                        SCREEN_FLIP,
  input  logic                        small_rom,
  input  logic [MAP_AW-1:0]           CPU_ADDR,
  input  logic [7:0]                  CPU_DIN,
  input  logic                        cpu_cs_lo_n,
  input  logic                        cpu_cs_hi_n,
  input  logic                        cpu_wr_n,
  output logic [7:0]                  cpu_dout_lo,
  output logic [7:0]                  cpu_dout_hi,
  output logic                        cpu_wait,
  output logic                        rom_req,
  output logic [ROM_AW-1:0]           rom_addr,
  input  logic                        rom_ack,
  input  logic [8*PLANES-1:0]         rom_data,
  output logic [COLOR_W+PLANES-1:0]   pixel_out,
  output logic                        underrun
);

  localparam int unsigned ColW     = MAP_AW - 5;
  localparam int unsigned MapDepth = 2 ** MAP_AW;
  localparam int unsigned WaitW    = $clog2(WAIT_CYCLES + 2);

  typedef enum logic [1:0] {StIdle, StMap, StReq, StReady} state_e;

  state_e state_q, state_d;

  logic [7:0] map_lo [MapDepth];
  logic [7:0] map_hi [MapDepth];
  logic       wr_lo, wr_hi;

  logic             cs_now, cs_q;
  logic [WaitW-1:0] wait_cnt_q;

  logic [2:0]          pix_idx;
  logic                trigger, boundary, buf_valid, start_fetch;
  logic [ColW-1:0]     col_next;
  logic [MAP_AW-1:0]   fetch_addr_q;
  logic [2:0]          line_q;
  logic                small_q;
  logic [15:0]         map_word;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [COLOR_W-1:0]  tile_color_q, color_q, color_d;
  logic [8*PLANES-1:0] buf_q, shift_q, shift_d;
  logic [PLANES-1:0]   pix_bits;

  assign wr_lo = !cpu_cs_lo_n && !cpu_wr_n;
  assign wr_hi = !cpu_cs_hi_n && !cpu_wr_n;

  // Map RAM CPU write port
  always_ff @(posedge master_clk) begin
    if (wr_lo) map_lo[CPU_ADDR] <= CPU_DIN;
    if (wr_hi) map_hi[CPU_ADDR] <= CPU_DIN;
  end

  // CPU read port; a write in the same cycle is forwarded so the new byte shows next cycle
  always_ff @(posedge master_clk) begin
    if (reset) begin
      cpu_dout_lo <= 8'h00;
      cpu_dout_hi <= 8'h00;
    end else begin
      cpu_dout_lo <= wr_lo ? CPU_DIN : map_lo[CPU_ADDR];
      cpu_dout_hi <= wr_hi ? CPU_DIN : map_hi[CPU_ADDR];
    end
  end

  assign cs_now   = !cpu_cs_lo_n || !cpu_cs_hi_n;
  assign cpu_wait = (wait_cnt_q != '0);

  // Wait-state counter, (re)started by each chip-select rising edge
  always_ff @(posedge master_clk) begin
    if (reset) begin
      cs_q       <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      cs_q <= cs_now;
      if (cs_now && !cs_q) begin
        wait_cnt_q <= WaitW'(WAIT_CYCLES);
      end else if (wait_cnt_q != '0) begin
        wait_cnt_q <= wait_cnt_q - WaitW'(1);
      end
    end
  end

  assign pix_idx   = HPIXSCRL[2:0];
  assign trigger   = ce_pix && (pix_idx == 3'd0);
  assign boundary  = ce_pix && (SCREEN_FLIP ? (pix_idx == 3'd0) : (pix_idx == 3'd7));
  assign buf_valid = (state_q == StReady);
  assign col_next  = ColW'(HPIXSCRL[8:3]) + ColW'(1);
  assign map_word  = {map_hi[fetch_addr_q], map_lo[fetch_addr_q]};
  assign rom_req   = (state_q == StReq);
  assign rom_addr  = ROM_AW'({code_q, line_q});

  // Fetch state register
  always_ff @(posedge master_clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Fetch next-state; a finished buffer may hand over and restart in the same cycle
  always_comb begin
    state_d     = state_q;
    start_fetch = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d     = StMap;
          start_fetch = 1'b1;
        end
      end
      StMap: state_d = StReq;
      StReq: begin
        if (rom_ack) state_d = StReady;
      end
      StReady: begin
        if (boundary) begin
          if (trigger) begin
            state_d     = StMap;
            start_fetch = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Tile code with the half-size ROM set forcing the top code bit low
  always_comb begin
    code_d = map_word[CODE_W-1:0];
    if (small_q) code_d[CODE_W-1] = 1'b0;
  end

  // Shifter next state and per-plane output bit
  always_comb begin
    shift_d  = shift_q;
    color_d  = color_q;
    pix_bits = '0;
    if (boundary) begin
      shift_d = buf_valid ? buf_q : '0;
      color_d = buf_valid ? tile_color_q : '0;
    end else begin
      for (int unsigned p = 0; p < PLANES; p++) begin
        shift_d[8*p +: 8] = SCREEN_FLIP ? (shift_q[8*p +: 8] >> 1) : (shift_q[8*p +: 8] << 1);
      end
    end
    for (int unsigned p = 0; p < PLANES; p++) begin
      pix_bits[p] = SCREEN_FLIP ? shift_d[8*p] : shift_d[8*p+7];
    end
  end

  // Fetch datapath, pixel shifters and sticky underrun flag
  always_ff @(posedge master_clk) begin
    if (reset) begin
      fetch_addr_q <= '0;
      line_q       <= 3'd0;
      small_q      <= 1'b0;
      code_q       <= '0;
      tile_color_q <= '0;
      buf_q        <= '0;
      shift_q      <= '0;
      color_q      <= '0;
      pixel_out    <= '0;
      underrun     <= 1'b0;
    end else begin
      if (start_fetch) begin
        fetch_addr_q <= {VPIXSCRL[7:3], col_next};
        line_q       <= VPIXSCRL[2:0];
        small_q      <= small_rom;
      end
      if (state_q == StMap) begin
        code_q       <= code_d;
        tile_color_q <= map_word[15 -: COLOR_W];
      end
      if ((state_q == StReq) && rom_ack) buf_q <= rom_data;
      if (ce_pix) begin
        shift_q   <= shift_d;
        color_q   <= color_d;
        pixel_out <= {color_d, pix_bits};
      end
      if (boundary && !buf_valid) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tile_layer_gen.sv
// Self-checking bench for tile_layer_gen: tile-level reference model feeding a pixel
// scoreboard and a ROM request queue, plus directed CPU-port and reset checks.
module tb_tile_layer_gen;

  localparam int unsigned PLANES      = 4;
  localparam int unsigned MAP_AW      = 11;
  localparam int unsigned CODE_W      = 12;
  localparam int unsigned COLOR_W     = 4;
  localparam int unsigned ROM_AW      = 17;
  localparam int unsigned WAIT_CYCLES = 2;

  logic        master_clk = 1'b0;
  logic        reset, ce_pix, SCREEN_FLIP, small_rom;
  logic [7:0]  VPIXSCRL;
  logic [8:0]  HPIXSCRL;
  logic [10:0] CPU_ADDR;
  logic [7:0]  CPU_DIN;
  logic        cpu_cs_lo_n, cpu_cs_hi_n, cpu_wr_n;
  logic [7:0]  cpu_dout_lo, cpu_dout_hi;
  logic        cpu_wait, rom_req, rom_ack, underrun;
  logic [16:0] rom_addr;
  logic [31:0] rom_data;
  logic [7:0]  pixel_out;

  always #5 master_clk = ~master_clk;

  tile_layer_gen #(
    .PLANES(PLANES), .MAP_AW(MAP_AW), .CODE_W(CODE_W), .COLOR_W(COLOR_W),
    .ROM_AW(ROM_AW), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .master_clk(master_clk), .reset(reset), .ce_pix(ce_pix), .VPIXSCRL(VPIXSCRL),
    .HPIXSCRL(HPIXSCRL), .SCREEN_FLIP(SCREEN_FLIP), .small_rom(small_rom),
    .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN), .cpu_cs_lo_n(cpu_cs_lo_n),
    .cpu_cs_hi_n(cpu_cs_hi_n), .cpu_wr_n(cpu_wr_n), .cpu_dout_lo(cpu_dout_lo),
    .cpu_dout_hi(cpu_dout_hi), .cpu_wait(cpu_wait), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .pixel_out(pixel_out), .underrun(underrun)
  );

  typedef struct packed {logic [7:0] pix; logic und;} exp_t;
  typedef struct packed {logic [16:0] addr; logic late;} req_t;

  exp_t pix_q[$];
  req_t req_q[$];
  int   total = 0;
  int   bad   = 0;

  logic [7:0] m_lo [2048];
  logic [7:0] m_hi [2048];

  // Reference model state: one outstanding fetch, one displayed tile
  bit          pend_valid, pend_late, late_next, tile_ok, m_under;
  logic [31:0] pend_data, tile_data;
  logic [3:0]  pend_col, tile_col;
  int          k;
  bit          mon_en = 1'b0;
  bit          resp_en = 1'b1;
  bit          want_first = 1'b0;
  logic [16:0] first_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom_fn(input logic [16:0] a);
    logic [31:0] x;
    x = {15'd0, a} * 32'h9E37_79B1;
    return x ^ (x >> 15) ^ 32'h3C5A_96E1;
  endfunction

  task automatic model_reset();
    pend_valid = 0; pend_late = 0; late_next = 0; tile_ok = 0; m_under = 0; k = 0;
    pend_data = '0; tile_data = '0; pend_col = '0; tile_col = '0;
  endtask

  // One pixel of the reference: tile boundary first, then a possible new fetch
  task automatic model_step();
    logic [2:0]  idx;
    logic [5:0]  c;
    logic [10:0] a;
    logic [15:0] w;
    logic [11:0] code;
    logic [16:0] ra;
    logic [3:0]  bits;
    bit          bnd;
    idx = HPIXSCRL[2:0];
    bnd = SCREEN_FLIP ? (idx == 3'd0) : (idx == 3'd7);
    if (bnd) begin
      k = 0;
      if (pend_valid && !pend_late) begin
        tile_ok = 1; tile_data = pend_data; tile_col = pend_col; pend_valid = 0;
      end else begin
        tile_ok = 0; m_under = 1; pend_late = 0;
      end
    end else begin
      k++;
    end
    if (idx == 3'd0 && !pend_valid) begin
      c = HPIXSCRL[8:3] + 6'd1;
      a = {VPIXSCRL[7:3], c};
      w = {m_hi[a], m_lo[a]};
      code = w[11:0];
      if (small_rom) code[11] = 1'b0;
      ra = {2'b00, code, VPIXSCRL[2:0]};
      pend_data = rom_fn(ra); pend_col = w[15:12];
      pend_valid = 1; pend_late = late_next; late_next = 0;
      req_q.push_back('{addr: ra, late: pend_late});
    end
    bits = '0;
    if (tile_ok) begin
      for (int p = 0; p < 4; p++) begin
        bits[p] = SCREEN_FLIP ? tile_data[8*p + k] : tile_data[8*p + 7 - k];
      end
    end
    pix_q.push_back('{pix: tile_ok ? {tile_col, bits} : 8'h00, und: m_under});
  endtask

  task automatic tick();
    @(posedge master_clk); #1;
  endtask

  task automatic pix();
    if (mon_en) model_step();
    ce_pix = 1'b1;
    tick();
    ce_pix = 1'b0;
    repeat (3) tick();
  endtask

  task automatic run_video(input bit f, input int ntiles, input int late_tile,
                           input logic [8:0] h0, input logic [7:0] v0);
    SCREEN_FLIP = f; HPIXSCRL = h0; VPIXSCRL = v0; small_rom = 1'b0;
    mon_en = 1'b1;
    for (int t = 0; t < ntiles * 8; t++) begin
      if (HPIXSCRL[2:0] == 3'd3) begin
        VPIXSCRL = 8'($urandom);
        if (t > 16) small_rom = 1'($urandom);
      end
      if (t == late_tile * 8 + 4) late_next = 1;
      pix();
      HPIXSCRL = HPIXSCRL + 9'd1;
    end
    repeat (20) tick();
    mon_en = 1'b0;
    check("req_queue_drained", 64'(req_q.size()), 64'd0);
    check("pix_queue_drained", 64'(pix_q.size()), 64'd0);
  endtask

  // Pixel monitor: compares every ce_pix result against the scoreboard
  initial begin
    bit   fired;
    exp_t e;
    forever begin
      @(posedge master_clk);
      fired = ce_pix && !reset && mon_en;
      @(negedge master_clk);
      if (fired) begin
        if (pix_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pixel: got %0h with no expected entry", pixel_out);
        end else begin
          e = pix_q.pop_front();
          check("pixel_out", 64'(pixel_out), 64'(e.pix));
          check("underrun", 64'(underrun), 64'(e.und));
        end
      end
    end
  end

  // ROM responder: checks each request address, answers after a short or long delay
  initial begin
    req_t r;
    int   d;
    bit   have;
    forever begin
      @(negedge master_clk);
      if (resp_en && rom_req) begin
        have = (req_q.size() != 0);
        r = '0;
        if (!have) begin
          total++; bad++;
          $display("FAIL rom_req: unexpected request addr %0h", rom_addr);
        end else begin
          r = req_q.pop_front();
          check("rom_addr", 64'(rom_addr), 64'(r.addr));
        end
        if (want_first) begin first_addr = rom_addr; want_first = 0; end
        d = r.late ? 40 : int'($urandom_range(1, 3));
        repeat (d - 1) @(negedge master_clk);
        if (have) check("rom_addr_hold", 64'(rom_addr), 64'(r.addr));
        rom_data = rom_fn(rom_addr);
        rom_ack  = 1'b1;
        @(negedge master_clk);
        rom_ack  = 1'b0;
        rom_data = '0;
        check("rom_req_drop", 64'(rom_req), 64'd0);
      end
    end
  end

  initial begin
    logic [10:0] a;
    int          n;
    bit          seen;
    reset = 1; ce_pix = 0; SCREEN_FLIP = 0; small_rom = 0; VPIXSCRL = 0; HPIXSCRL = 0;
    CPU_ADDR = 0; CPU_DIN = 0; cpu_cs_lo_n = 1; cpu_cs_hi_n = 1; cpu_wr_n = 1;
    rom_ack = 0; rom_data = '0;
    model_reset();
    repeat (3) tick();
    check("rst_pixel_out", 64'(pixel_out), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_rom_req", 64'(rom_req), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_cpu_wait", 64'(cpu_wait), 64'd0);
    check("rst_cpu_dout", 64'({cpu_dout_hi, cpu_dout_lo}), 64'd0);
    reset = 0;
    tick();

    // Write strobe: wait high for exactly WAIT_CYCLES, new byte readable next cycle
    CPU_ADDR = 11'd5; CPU_DIN = 8'hA7; cpu_cs_lo_n = 0; cpu_wr_n = 0;
    check("wait_before_edge", 64'(cpu_wait), 64'd0);
    tick();
    cpu_cs_lo_n = 1; cpu_wr_n = 1;
    check("dout_lo_new", 64'(cpu_dout_lo), 64'hA7);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      n += int'(cpu_wait);
      tick();
    end
    check("wait_cycles", 64'(n), 64'(WAIT_CYCLES));

    // Second edge during the count restarts it
    cpu_cs_hi_n = 0;
    tick();
    cpu_cs_hi_n = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 1) cpu_cs_hi_n = 0;
      if (i == 2) cpu_cs_hi_n = 1;
      n += int'(cpu_wait);
      tick();
    end
    check("wait_restart", 64'(n), 64'd4);

    // Fill the tilemap with random entries, (row0,col1) = lo 0x34 hi 0x52
    for (int i = 0; i < 2048; i++) begin
      m_lo[i] = 8'($urandom);
      m_hi[i] = 8'($urandom);
    end
    m_lo[1] = 8'h34; m_hi[1] = 8'h52;
    cpu_wr_n = 0; cpu_cs_lo_n = 0;
    for (int i = 0; i < 2048; i++) begin
      CPU_ADDR = 11'(i); CPU_DIN = m_lo[i]; tick();
    end
    cpu_cs_lo_n = 1; cpu_cs_hi_n = 0;
    for (int i = 0; i < 2048; i++) begin
      CPU_ADDR = 11'(i); CPU_DIN = m_hi[i]; tick();
    end
    cpu_cs_hi_n = 1; cpu_wr_n = 1;
    for (int i = 0; i < 4; i++) begin
      a = 11'($urandom);
      CPU_ADDR = a;
      tick();
      check("readback_lo", 64'(cpu_dout_lo), 64'(m_lo[a]));
      check("readback_hi", 64'(cpu_dout_hi), 64'(m_hi[a]));
    end

    // Normal order, one long-latency fetch in the middle
    want_first = 1;
    run_video(1'b0, 30, 12, 9'd0, 8'd3);
    check("first_rom_addr", 64'(first_addr), 64'h011A3);

    // Flipped order after a fresh reset
    reset = 1; SCREEN_FLIP = 1;
    repeat (2) tick();
    model_reset();
    reset = 0;
    tick();
    run_video(1'b1, 30, 10, {6'($urandom), 3'b000}, 8'($urandom));

    // Reset in the middle of a request, then a stale ack
    reset = 1; SCREEN_FLIP = 0; resp_en = 0;
    repeat (2) tick();
    reset = 0; HPIXSCRL = 9'd0; VPIXSCRL = 8'd0;
    ce_pix = 1; tick(); ce_pix = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (rom_req) seen = 1;
      else tick();
    end
    check("req_seen", 64'(seen), 64'd1);
    reset = 1; tick();
    check("req_after_reset", 64'(rom_req), 64'd0);
    reset = 0;
    rom_ack = 1; rom_data = 32'hFFFF_FFFF; tick();
    rom_ack = 0; rom_data = '0;
    check("stale_ack_req", 64'(rom_req), 64'd0);
    check("stale_ack_addr", 64'(rom_addr), 64'd0);
    for (int h = 1; h < 8; h++) begin
      HPIXSCRL = 9'(h);
      ce_pix = 1; tick(); ce_pix = 0;
      check("stale_pixel", 64'(pixel_out), 64'd0);
      check("stale_underrun", 64'(underrun), 64'(h == 7));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
